// File: rtl/handshake_slave.sv
// Valid/ready FIFO slave with an incrementing-sequence checker on the accepted stream.
// Accepted words are buffered in order; mismatches raise a sticky flag and a saturating count.
module handshake_slave #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     s_ready,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  input  logic                     o_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     seq_err,
  input  logic                     err_clr,
  output logic [7:0]               err_cnt,
  output logic [15:0]              rx_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic {IDLE, TRACK} chk_state_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  chk_state_t       r_state;
  logic [WIDTH-1:0] r_expected;
  logic             r_seq_err;
  logic [7:0]       r_err_cnt;
  logic [15:0]      r_rx_cnt;

  logic             w_accept;
  logic             w_pop;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_next_exp;

  // Handshake flags come only from the registered level, so s_ready never depends on o_ready.
  assign s_ready    = (r_level < FULL_LEVEL);
  assign o_valid    = (r_level != '0);
  assign o_data     = r_mem[r_rd_ptr];
  assign level      = r_level;

  assign w_accept   = s_valid & s_ready;
  assign w_pop      = o_valid & o_ready;
  assign w_next_exp = s_data + 1'b1;
  assign w_mismatch = w_accept && (r_state == TRACK) && (s_data != r_expected);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; contents are unreachable until written because level gates o_valid.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_expected <= '0;
      r_seq_err  <= 1'b0;
      r_err_cnt  <= '0;
      r_rx_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_rx_cnt   <= r_rx_cnt + 16'd1;
        r_expected <= w_next_exp;
        case (r_state)
          IDLE:    r_state <= TRACK;
          default: r_state <= TRACK;
        endcase
      end
      // A mismatch on the same edge as err_clr keeps the flag set.
      if (w_mismatch) begin
        r_seq_err <= 1'b1;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (err_clr) begin
        r_seq_err <= 1'b0;
      end
    end
  end

  assign seq_err = r_seq_err;
  assign err_cnt = r_err_cnt;
  assign rx_cnt  = r_rx_cnt;

endmodule

// File: doc/handshake_slave.md
HANDSHAKE_SLAVE -- requirements
Module: handshake_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the buffer depth in words; legal values are powers of two, 2 or more.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port s_valid  input  1  upstream word valid.
REQ-006 SHALL have port s_data  input  WIDTH  upstream word.
REQ-007 SHALL have port s_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port o_valid  output  1  buffered word available downstream.
REQ-009 SHALL have port o_data  output  WIDTH  oldest buffered word.
REQ-010 SHALL have port o_ready  input  1  downstream accepts o_data.
REQ-011 SHALL have port level  output  clog2(DEPTH)+1  number of words held.
REQ-012 SHALL have port seq_err  output  1  sticky sequence-error flag.
REQ-013 SHALL have port err_clr  input  1  synchronous clear of seq_err.
REQ-014 SHALL have port err_cnt  output  8  mismatch count, saturating.
REQ-015 SHALL have port rx_cnt  output  16  accepted-word count, wrapping.

Function
REQ-016 SHALL define upstream accept as s_valid & s_ready, and downstream pop as o_valid & o_ready, both evaluated at the rising edge.
REQ-017 SHALL drive s_ready = (level < DEPTH) from registered state only, with no combinational path from s_valid or o_ready.
REQ-018 SHALL drive o_valid = (level != 0), with o_data equal to the entry at the read pointer.
REQ-019 SHALL provide first-word latency of 1 cycle: a word accepted at edge N appears on o_valid/o_data after edge N.
REQ-020 SHALL keep the word order of the FIFO; read and write pointers wrap modulo DEPTH.
REQ-021 SHALL, on accept and pop in the same edge, leave level unchanged, advance both pointers, and lose no data.
REQ-022 SHALL hold s_ready low when full; there is no pass-through, so a word is not accepted even if a pop occurs in the same cycle.
REQ-023 SHALL perform no pop when empty; o_data is don't-care while o_valid is 0.
REQ-024 SHALL keep o_data stable while o_valid=1 and o_ready=0.
REQ-025 SHALL implement sequence checker states IDLE (no word yet seen) and TRACK (holding a WIDTH-bit expected value).
REQ-026 SHALL, on the first accept in IDLE, load expected = s_data+1 (mod 2^WIDTH), move to TRACK, and report no error.
REQ-027 SHALL, on an accept in TRACK with s_data == expected, load expected = s_data+1; wrap from 2^WIDTH-1 to 0 is legal.
REQ-028 SHALL, on an accept in TRACK with s_data != expected, set seq_err, increment err_cnt (saturating at 255), and resync expected = s_data+1.
REQ-029 SHALL clear seq_err on an edge with err_clr=1; if a mismatch occurs on the same edge, set wins; err_clr does not affect err_cnt.
REQ-030 SHALL increment rx_cnt by 1 per accept, wrapping from 65535 to 0.
REQ-031 SHALL leave the checker and counters unchanged by pops.

Reset
REQ-032 SHALL, while rst=1, immediately force level=0, pointers=0, s_ready=1, o_valid=0, seq_err=0, err_cnt=0, rx_cnt=0, and checker state IDLE, independent of clk.
REQ-033 SHALL discard buffered contents on reset mid-operation; the first accept after release is treated as the first word (IDLE).
REQ-034 SHALL, for the first edge after rst deasserts, accept normally if s_valid=1.

Verification
REQ-035 SHALL be verified by this scenario: with o_ready=1, stream 0,1,2,...,9 continuously -> output 0..9 in order at 1-cycle latency, rx_cnt=10, seq_err=0, level never above 1.
REQ-036 SHALL be verified by this scenario: with o_ready=0, drive 6 valid words 0..5 with DEPTH=4 -> words 0..3 accepted, s_ready=0 after the 4th, level=4; then raise o_ready -> 0..5 drained in order.
REQ-037 SHALL be verified by this scenario: with the buffer full and s_valid=1, set o_ready=1 for one cycle -> one pop, no accept that edge, level=3; on the next edge the accept occurs and level=4.
REQ-038 SHALL be verified by this scenario: send 254,255,0,1 -> seq_err=0; then send 5 -> seq_err=1, err_cnt=1; then send 6 -> no new error.
REQ-039 SHALL be verified by this scenario: with seq_err=1, assert err_clr on the same edge as a mismatching word -> seq_err stays 1 and err_cnt increments; err_clr alone -> seq_err=0 with err_cnt unchanged.
REQ-040 SHALL be verified by this scenario: assert rst asynchronously between edges with level=3 -> outputs clear immediately; after release, sending 42 -> no error, rx_cnt=1.
